jacobian_to_affine: RTL

- Converts a Jacobian point (X, Y, Z) into affine coordinates: x = X·Z^-2 mod p, y = Y·Z^-3 mod p.
- Sits on the output side of the point-doubling/point-addition datapath and is the exit path from projective form.
- Sequences one modular inversion followed by four modular multiplications through a start/done handshake.
- Flags the point at infinity when Z = 0.

---
 rtl/ecc_pkg.sv | 24 ++
 rtl/mod_inverse.sv | 106 ++++++++++
 rtl/modular_multiplication.sv | 82 ++++++++
 rtl/jacobian_to_affine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the Jacobian-to-affine exit path.
// Coordinates are ECC_W bits; the FSM walks one inversion then three multiply stages.
package ecc_pkg;

  localparam int ECC_W = 256;

  typedef logic [ECC_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CHKZ,
    INV,
    M1,
    M2,
    M3,
    FIN
  } state_t;

  localparam coord_t P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam coord_t P23  = 256'd23;
  localparam coord_t P97  = 256'd97;

endpackage

// File: rtl/mod_inverse.sv
// Binary extended Euclidean inverse a^-1 mod p (p odd), one reduction step per cycle.
// Invariants: x1*a == u and x2*a == v (mod p); finishes when u or v reaches 1.
module mod_inverse #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_p,
  output logic [W-1:0] o_inv,
  output logic         o_done
);

  logic         busy_q, busy_d;
  logic [W-1:0] u_q, u_d;
  logic [W-1:0] v_q, v_d;
  logic [W-1:0] x1_q, x1_d;
  logic [W-1:0] x2_q, x2_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] inv_q, inv_d;
  logic         done_q, done_d;

  // x/2 mod p: odd x becomes (x+p)/2, which stays below p.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] p);
    return x[0] ? W'(({1'b0, x} + {1'b0, p}) >> 1) : (x >> 1);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] p);
    return (a >= b) ? (a - b) : W'({1'b0, a} + {1'b0, p} - {1'b0, b});
  endfunction

  always_comb begin
    busy_d = busy_q;
    u_d    = u_q;
    v_d    = v_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    p_d    = p_q;
    inv_d  = inv_q;
    done_d = 1'b0;

    if (!busy_q) begin
      if (i_start) begin
        u_d    = i_a;
        v_d    = i_p;
        x1_d   = W'(1);
        x2_d   = '0;
        p_d    = i_p;
        busy_d = 1'b1;
      end
    end else if (u_q == W'(1)) begin
      inv_d  = x1_q;
      done_d = 1'b1;
      busy_d = 1'b0;
    end else if (v_q == W'(1)) begin
      inv_d  = x2_q;
      done_d = 1'b1;
      busy_d = 1'b0;
    end else if (u_q == '0) begin
      // Zero has no inverse; terminate rather than spin forever.
      inv_d  = '0;
      done_d = 1'b1;
      busy_d = 1'b0;
    end else if (!u_q[0]) begin
      u_d  = u_q >> 1;
      x1_d = half_mod(x1_q, p_q);
    end else if (!v_q[0]) begin
      v_d  = v_q >> 1;
      x2_d = half_mod(x2_q, p_q);
    end else if (u_q >= v_q) begin
      u_d  = u_q - v_q;
      x1_d = sub_mod(x1_q, x2_q, p_q);
    end else begin
      v_d  = v_q - u_q;
      x2_d = sub_mod(x2_q, x1_q, p_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      p_q    <= '0;
      inv_q  <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      u_q    <= u_d;
      v_q    <= v_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      p_q    <= p_d;
      inv_q  <= inv_d;
      done_q <= done_d;
    end
  end

  assign o_inv  = inv_q;
  assign o_done = done_q;

endmodule

// File: rtl/modular_multiplication.sv
// Interleaved shift-add modular multiplier: result = a*b mod m, one bit of b per cycle.
// Latency W cycles after the start cycle; o_ready drops the cycle after start, result holds while ready.
module modular_multiplication #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_result,
  output logic         o_ready
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  logic [W:0]    dbl;
  logic [W-1:0]  dbl_r;
  logic [W:0]    sum;
  logic [W-1:0]  sum_r;

  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;

    // Operands are < m, so one conditional subtract after each step keeps acc < m.
    dbl   = {acc_q, 1'b0};
    dbl_r = (dbl >= {1'b0, m_q}) ? W'(dbl - {1'b0, m_q}) : W'(dbl);
    sum   = b_q[W-1] ? ({1'b0, dbl_r} + {1'b0, a_q}) : {1'b0, dbl_r};
    sum_r = (sum >= {1'b0, m_q}) ? W'(sum - {1'b0, m_q}) : W'(sum);

    if (ready_q) begin
      if (i_start) begin
        acc_d   = '0;
        a_d     = i_a;
        b_d     = i_b;
        m_d     = i_m;
        cnt_d   = CW'(W);
        ready_d = 1'b0;
      end
    end else begin
      acc_d = sum_r;
      b_d   = {b_q[W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) ready_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign o_result = acc_q;
  assign o_ready  = ready_q;

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) to affine: x = X*Z^-2, y = Y*Z^-3 mod p; Z = 0 reports the point at infinity.
// Sequence: one inversion, then z2 = zi^2, {x = X*z2, z3 = z2*zi} in parallel, y = Y*z3.
module jacobian_to_affine
  import ecc_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_X,
  input  logic [W-1:0] i_Y,
  input  logic [W-1:0] i_Z,
  input  logic [W-1:0] i_p,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_inf,
  output logic         o_busy,
  output logic         o_done
);

  state_t       state_q, state_d;
  logic         start_prev_q;
  logic [W-1:0] cx_q, cx_d, cy_q, cy_d, cz_q, cz_d, cp_q, cp_d;
  logic [W-1:0] zi_q, zi_d, z2_q, z2_d, z3_q, z3_d;
  logic [W-1:0] xr_q, xr_d, yr_q, yr_d;
  logic [W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic         inf_q, inf_d, busy_q, busy_d, done_q, done_d;
  logic         inv_start_q, inv_start_d;
  logic         m0_start_q, m0_start_d, m1_start_q, m1_start_d;
  logic         m0_low_q, m0_low_d, m1_low_q, m1_low_d;
  logic         m0_ok_q, m0_ok_d, m1_ok_q, m1_ok_d;

  logic         accept;
  logic         mul_rst_n;
  logic [W-1:0] inv_out;
  logic         inv_done;
  logic [W-1:0] m0_a, m0_b, m1_a, m1_b, m0_res, m1_res;
  logic         m0_rdy, m1_rdy, m0_fin, m1_fin;

  assign mul_rst_n = ~i_rst;

  mod_inverse #(.W(W)) u_inv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (inv_start_q),
    .i_a     (cz_q),
    .i_p     (cp_q),
    .o_inv   (inv_out),
    .o_done  (inv_done)
  );

  modular_multiplication #(.W(W)) u_mul0 (
    .i_clk    (i_clk),
    .i_rst_n  (mul_rst_n),
    .i_start  (m0_start_q),
    .i_a      (m0_a),
    .i_b      (m0_b),
    .i_m      (cp_q),
    .o_result (m0_res),
    .o_ready  (m0_rdy)
  );

  modular_multiplication #(.W(W)) u_mul1 (
    .i_clk    (i_clk),
    .i_rst_n  (mul_rst_n),
    .i_start  (m1_start_q),
    .i_a      (m1_a),
    .i_b      (m1_b),
    .i_m      (cp_q),
    .o_result (m1_res),
    .o_ready  (m1_rdy)
  );

  // Operands are sampled by the multiplier in the first cycle of each multiply state.
  always_comb begin
    m0_a = zi_q;
    m0_b = zi_q;
    case (state_q)
      M2: begin
        m0_a = cx_q;
        m0_b = z2_q;
      end
      M3: begin
        m0_a = cy_q;
        m0_b = z3_q;
      end
      default: ;
    endcase
    m1_a = z2_q;
    m1_b = zi_q;
  end

  // Ready may still be high from the last product, so completion needs a low-then-high.
  assign m0_fin = m0_ok_q | (m0_low_q & m0_rdy);
  assign m1_fin = m1_ok_q | (m1_low_q & m1_rdy);
  assign accept = i_start & ~start_prev_q & (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    cz_d        = cz_q;
    cp_d        = cp_q;
    zi_d        = zi_q;
    z2_d        = z2_q;
    z3_d        = z3_q;
    xr_d        = xr_q;
    yr_d        = yr_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    inf_d       = inf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inv_start_d = 1'b0;
    m0_start_d  = 1'b0;
    m1_start_d  = 1'b0;
    m0_low_d    = m0_low_q | ~m0_rdy;
    m1_low_d    = m1_low_q | ~m1_rdy;
    m0_ok_d     = m0_fin;
    m1_ok_d     = m1_fin;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cx_d    = i_X;
          cy_d    = i_Y;
          cz_d    = i_Z;
          cp_d    = i_p;
          busy_d  = 1'b1;
          inf_d   = 1'b0;
          state_d = CHKZ;
        end
      end
      CHKZ: begin
        if (cz_q == '0) begin
          inf_d   = 1'b1;
          xr_d    = '0;
          yr_d    = '0;
          state_d = FIN;
        end else begin
          inv_start_d = 1'b1;
          state_d     = INV;
        end
      end
      INV: begin
        if (inv_done) begin
          zi_d       = inv_out;
          m0_start_d = 1'b1;
          m0_low_d   = 1'b0;
          m0_ok_d    = 1'b0;
          state_d    = M1;
        end
      end
      M1: begin
        if (m0_fin) begin
          z2_d       = m0_res;
          m0_start_d = 1'b1;
          m1_start_d = 1'b1;
          m0_low_d   = 1'b0;
          m1_low_d   = 1'b0;
          m0_ok_d    = 1'b0;
          m1_ok_d    = 1'b0;
          state_d    = M2;
        end
      end
      M2: begin
        if (m0_fin && m1_fin) begin
          xr_d       = m0_res;
          z3_d       = m1_res;
          m0_start_d = 1'b1;
          m0_low_d   = 1'b0;
          m0_ok_d    = 1'b0;
          state_d    = M3;
        end
      end
      M3: begin
        if (m0_fin) begin
          yr_d    = m0_res;
          state_d = FIN;
        end
      end
      FIN: begin
        ox_d    = xr_q;
        oy_d    = yr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      cz_q         <= '0;
      cp_q         <= '0;
      zi_q         <= '0;
      z2_q         <= '0;
      z3_q         <= '0;
      xr_q         <= '0;
      yr_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      inf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      inv_start_q  <= 1'b0;
      m0_start_q   <= 1'b0;
      m1_start_q   <= 1'b0;
      m0_low_q     <= 1'b0;
      m1_low_q     <= 1'b0;
      m0_ok_q      <= 1'b0;
      m1_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= i_start;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      cz_q         <= cz_d;
      cp_q         <= cp_d;
      zi_q         <= zi_d;
      z2_q         <= z2_d;
      z3_q         <= z3_d;
      xr_q         <= xr_d;
      yr_q         <= yr_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      inf_q        <= inf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      inv_start_q  <= inv_start_d;
      m0_start_q   <= m0_start_d;
      m1_start_q   <= m1_start_d;
      m0_low_q     <= m0_low_d;
      m1_low_q     <= m1_low_d;
      m0_ok_q      <= m0_ok_d;
      m1_ok_q      <= m1_ok_d;
    end
  end

  assign o_x    = ox_q;
  assign o_y    = oy_q;
  assign o_inf  = inf_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
